// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: operand word, opcodes, request and response records.
package alu_pkg;

    typedef logic [3:0] alu_word_t;

    localparam alu_word_t ALU_OR  = 4'd0;
    localparam alu_word_t ALU_AND = 4'd1;
    localparam alu_word_t ALU_SUB = 4'd2;
    localparam alu_word_t ALU_ADD = 4'd3;

    typedef struct packed {
        alu_word_t a;
        alu_word_t b;
        alu_word_t op;
    } alu_req_t;

    // Packs as {a, b, op, out1, out2}, which is exactly the 20-bit response payload.
    typedef struct packed {
        alu_req_t  req;
        alu_word_t out1;
        alu_word_t out2;
    } alu_rsp_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO holding ALU requests with their sequence tags.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  alu_req_t                   push_req,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output alu_req_t                   head_req,
    output logic [TAG_W-1:0]           head_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    alu_req_t         req_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign head_req = req_mem[rptr];
    assign head_tag = tag_mem[rptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            req_mem[wptr] <= push_req;
            tag_mem[wptr] <= push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around an external combinational ALU: request FIFO, operand register, response register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_a,
    input  logic [3:0]                 req_b,
    input  logic [3:0]                 req_op,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [3:0]                 alu_op,
    input  logic [3:0]                 alu_out1,
    input  logic [3:0]                 alu_out2,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [19:0]                rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    alu_req_t         req_in;
    alu_req_t         head_req;
    alu_req_t         iss_req;
    alu_rsp_t         rsp_q;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] iss_tag;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [TAG_W-1:0] tag_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             iss_valid;
    logic             rsp_valid_q;
    logic             rsp_load;

    assign req_in = '{a: req_a, b: req_b, op: req_op};

    // Ready depends only on FIFO occupancy (and reset), never on rsp_ready.
    assign req_ready = !rst && !fifo_full;
    assign push      = req_valid && req_ready;
    assign rsp_load  = iss_valid && (!rsp_valid_q || rsp_ready);
    assign pop       = !fifo_empty && (!iss_valid || rsp_load);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (req_in),
        .push_tag (tag_cnt),
        .pop      (pop),
        .head_req (head_req),
        .head_tag (head_tag),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_cnt <= '0;
        end else if (push) begin
            tag_cnt <= tag_cnt + TAG_W'(1);
        end
    end

    // Operands are only reloaded on a pop, so the ALU inputs hold through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_req   <= '0;
            iss_tag   <= '0;
        end else if (pop) begin
            iss_valid <= 1'b1;
            iss_req   <= head_req;
            iss_tag   <= head_tag;
        end else if (rsp_load) begin
            iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            rsp_tag_q   <= '0;
        end else if (rsp_load) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{req: iss_req, out1: alu_out1, out2: alu_out2};
            rsp_tag_q   <= iss_tag;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu_a     = iss_req.a;
    assign alu_b     = iss_req.b;
    assign alu_op    = iss_req.op;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;
    assign rsp_tag   = rsp_tag_q;

endmodule
